// File: rtl/avmm_mailbox_slave.sv
// avmm_mailbox_slave: Avalon-MM 16-bit mailbox between Qsys masters and the synapse316 MCU
module mbx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] wdata,
    output logic [15:0] head,
    output logic        empty,
    output logic        full
);
    localparam int AW = $clog2(DEPTH);
    logic [15:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic        push_ok, pop_ok;
    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head    = empty ? 16'h0 : mem[rp[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    // pointers carry a wrap bit so full and empty are distinguishable
    always_ff @(posedge sysclk or posedge sysreset)
        if (sysreset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + {{AW{1'b0}}, push_ok};
            rp <= rp + {{AW{1'b0}}, pop_ok};
        end
    // storage needs no reset; contents are only visible through the pointers
    always_ff @(posedge sysclk)
        if (push_ok) mem[wp[AW-1:0]] <= wdata;
endmodule

module avmm_mailbox_slave #(
    parameter int DEPTH   = 16,
    parameter int DB_BITS = 4
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic [1:0]  s0_address,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [15:0] s0_writedata,
    output logic [15:0] s0_readdata,
    output logic        s0_waitrequest,
    input  logic [15:0] data_in,
    input  logic        m2a_load,
    output logic [15:0] a2m_out,
    input  logic        a2m_read,
    input  logic        db_clear_load,
    output logic [15:0] status_out,
    output logic        a2m_ready,
    output logic        db_pending
);
    logic               ack, fire, av_wr, av_rd;
    logic               a2m_empty, a2m_full, m2a_empty, m2a_full;
    logic [15:0]        m2a_head, scratch, rd_mux;
    logic [2:0]         flags, flag_set, flag_clr;
    logic [DB_BITS-1:0] db, db_set, db_clr;
    assign fire           = (s0_read || s0_write) && !ack;
    assign av_wr          = fire && s0_write;
    assign av_rd          = fire && s0_read && !s0_write;
    assign s0_waitrequest = sysreset || ((s0_read || s0_write) && !ack);
    assign a2m_ready      = !a2m_empty;
    assign db_pending     = |db;
    mbx_fifo #(.DEPTH(DEPTH)) u_a2m (
        .sysclk(sysclk), .sysreset(sysreset),
        .push(av_wr && s0_address == 2'd0), .pop(a2m_read), .wdata(s0_writedata),
        .head(a2m_out), .empty(a2m_empty), .full(a2m_full)
    );
    mbx_fifo #(.DEPTH(DEPTH)) u_m2a (
        .sysclk(sysclk), .sysreset(sysreset),
        .push(m2a_load), .pop(av_rd && s0_address == 2'd0), .wdata(data_in),
        .head(m2a_head), .empty(m2a_empty), .full(m2a_full)
    );
    // sticky flag sources, W1C masks, doorbell set/clear and the read mux
    always_comb begin
        flag_set = {m2a_load && m2a_full,
                    av_rd && s0_address == 2'd0 && m2a_empty,
                    av_wr && s0_address == 2'd0 && a2m_full};
        flag_clr = (av_wr && s0_address == 2'd1) ? s0_writedata[6:4] : 3'b0;
        db_set   = (av_wr && s0_address == 2'd3) ? s0_writedata[DB_BITS-1:0] : '0;
        db_clr   = db_clear_load ? data_in[DB_BITS-1:0] : '0;
        status_out = 16'h0;
        status_out[3:0] = {m2a_full, m2a_empty, a2m_full, a2m_empty};
        status_out[6:4] = flags;
        status_out[8 +: DB_BITS] = db;
        rd_mux = s0_address == 2'd0 ? m2a_head :
                 s0_address == 2'd1 ? status_out :
                 s0_address == 2'd2 ? scratch : 16'(db);
    end
    // handshake, registered read data, scratch, sticky flags and doorbell; sets beat clears
    always_ff @(posedge sysclk or posedge sysreset)
        if (sysreset) begin
            ack         <= 1'b0;
            s0_readdata <= 16'h0;
            scratch     <= 16'h0;
            flags       <= 3'b0;
            db          <= '0;
        end else begin
            ack   <= fire;
            flags <= flag_set | (flags & ~flag_clr);
            db    <= db_set | (db & ~db_clr);
            if (av_wr && s0_address == 2'd2) scratch <= s0_writedata;
            if (av_rd) s0_readdata <= rd_mux;
            else if (av_wr && s0_read) s0_readdata <= 16'h0;
        end
endmodule

// File: tb/tb_avmm_mailbox_slave.sv
// tb_avmm_mailbox_slave: randomized bench for the mailbox against a queue-based reference model
module tb_avmm_mailbox_slave;
    localparam int DEPTH = 16;
    localparam int DB    = 4;

    logic        sysclk = 1'b0, sysreset = 1'b0;
    logic [1:0]  s0_address = '0;
    logic        s0_read = 1'b0, s0_write = 1'b0;
    logic [15:0] s0_writedata = '0, data_in = '0;
    logic        m2a_load = 1'b0, a2m_read = 1'b0, db_clear_load = 1'b0;
    logic [15:0] s0_readdata, a2m_out, status_out;
    logic        s0_waitrequest, a2m_ready, db_pending;

    int checks = 0, errors = 0;

    logic [15:0]   a2m_q[$], m2a_q[$];
    logic          a2m_ovf, m2a_unf, m2a_ovf;
    logic [DB-1:0] db;
    logic [15:0]   scratch, last_rd;

    avmm_mailbox_slave #(.DEPTH(DEPTH), .DB_BITS(DB)) dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_readdata(s0_readdata), .s0_waitrequest(s0_waitrequest),
        .data_in(data_in), .m2a_load(m2a_load), .a2m_out(a2m_out), .a2m_read(a2m_read),
        .db_clear_load(db_clear_load), .status_out(status_out),
        .a2m_ready(a2m_ready), .db_pending(db_pending)
    );

    always #5 sysclk = ~sysclk;

    function automatic void model_reset();
        a2m_q.delete(); m2a_q.delete();
        a2m_ovf = 0; m2a_unf = 0; m2a_ovf = 0; db = '0; scratch = '0; last_rd = '0;
    endfunction

    function automatic logic [15:0] model_status();
        return {4'h0, db, 1'b0, m2a_ovf, m2a_unf, a2m_ovf,
                m2a_q.size() == DEPTH, m2a_q.size() == 0, a2m_q.size() == DEPTH, a2m_q.size() == 0};
    endfunction

    // one cycle of mailbox behaviour; returns what s0_readdata should hold afterwards
    function automatic logic [15:0] model_step(input logic rd, input logic wr, input logic [1:0] addr,
            input logic [15:0] wd, input logic pop, input logic clr, input logic [15:0] d, input logic load);
        int na = a2m_q.size();
        int nm = m2a_q.size();
        logic [15:0] r;
        logic sa = 0, su = 0, so = 0;
        logic [2:0] w = 0;
        logic [DB-1:0] dbs = 0, dbc = 0;
        if (wr) r = rd ? 16'h0 : last_rd;
        else if (rd) r = addr == 0 ? (nm > 0 ? m2a_q[0] : 16'h0) : addr == 1 ? model_status() :
                         addr == 2 ? scratch : {12'h0, db};
        else r = last_rd;
        if (pop && na > 0) void'(a2m_q.pop_front());
        if (wr && addr == 0) begin if (na < DEPTH) a2m_q.push_back(wd); else sa = 1; end
        if (rd && !wr && addr == 0) begin if (nm > 0) void'(m2a_q.pop_front()); else su = 1; end
        if (load) begin if (nm < DEPTH) m2a_q.push_back(d); else so = 1; end
        if (wr && addr == 1) w = wd[6:4];
        if (wr && addr == 2) scratch = wd;
        if (wr && addr == 3) dbs = wd[DB-1:0];
        if (clr) dbc = d[DB-1:0];
        a2m_ovf = sa | (a2m_ovf & ~w[0]);
        m2a_unf = su | (m2a_unf & ~w[1]);
        m2a_ovf = so | (m2a_ovf & ~w[2]);
        db = dbs | (db & ~dbc);
        last_rd = r;
        return r;
    endfunction

    // full two-cycle Avalon transfer with optional MCU activity during cycle N; hs=1 if stall pattern was 1 then 0
    task automatic av_xfer(input logic rd, input logic wr, input logic [1:0] addr, input logic [15:0] wd,
            input logic pop, input logic clr, input logic [15:0] d, input logic load,
            output logic [15:0] got, output logic [15:0] exp, output logic hs);
        @(negedge sysclk);
        s0_read = rd; s0_write = wr; s0_address = addr; s0_writedata = wd;
        a2m_read = pop; db_clear_load = clr; data_in = d; m2a_load = load;
        #1 hs = s0_waitrequest === 1'b1;
        exp = model_step(rd, wr, addr, wd, pop, clr, d, load);
        @(posedge sysclk); #1;
        a2m_read = 0; db_clear_load = 0; m2a_load = 0;
        @(negedge sysclk);
        hs = hs && s0_waitrequest === 1'b0;
        got = s0_readdata;
        @(posedge sysclk); #1;
        s0_read = 0; s0_write = 0;
    endtask

    task automatic mcu_op(input logic pop, input logic clr, input logic [15:0] d, input logic load);
        @(negedge sysclk);
        a2m_read = pop; db_clear_load = clr; data_in = d; m2a_load = load;
        void'(model_step(0, 0, 2'd0, 16'h0, pop, clr, d, load));
        @(posedge sysclk); #1;
        a2m_read = 0; db_clear_load = 0; m2a_load = 0;
    endtask

    task automatic test_reset();
        #1 sysreset = 1; s0_read = 1; s0_address = 2'd1;
        repeat (2) @(negedge sysclk);
        checks++; if (s0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait got %b exp 1", s0_waitrequest); end
        checks++; if (s0_readdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0000", s0_readdata); end
        checks++; if (status_out !== 16'h0005) begin errors++; $display("FAIL rst_status got %h exp 0005", status_out); end
        checks++; if ({a2m_ready, db_pending, a2m_out} !== 18'h0) begin errors++; $display("FAIL rst_mcu got %b %b %h exp 0 0 0000", a2m_ready, db_pending, a2m_out); end
        sysreset = 0; model_reset();
        #1;
        checks++; if (s0_waitrequest !== 1'b1) begin errors++; $display("FAIL st_cycle_n_wait got %b exp 1", s0_waitrequest); end
        @(posedge sysclk); @(negedge sysclk);
        checks++; if (s0_waitrequest !== 1'b0) begin errors++; $display("FAIL st_cycle_n1_wait got %b exp 0", s0_waitrequest); end
        checks++; if (s0_readdata !== 16'h0005) begin errors++; $display("FAIL st_read got %h exp 0005", s0_readdata); end
        @(posedge sysclk); #1 s0_read = 0;
        last_rd = 16'h0005;
    endtask

    task automatic test_a2m();
        logic [15:0] got, exp; logic hs;
        int n;
        av_xfer(0, 1, 2'd0, 16'h1111, 0, 0, 0, 0, got, exp, hs);
        av_xfer(0, 1, 2'd0, 16'h2222, 0, 0, 0, 0, got, exp, hs);
        checks++; if (!hs) begin errors++; $display("FAIL a2m_wr_hs got 0 exp 1"); end
        checks++; if (a2m_out !== 16'h1111 || a2m_ready !== 1'b1) begin errors++; $display("FAIL a2m_head1 got %h %b exp 1111 1", a2m_out, a2m_ready); end
        mcu_op(1, 0, 0, 0);
        checks++; if (a2m_out !== 16'h2222) begin errors++; $display("FAIL a2m_head2 got %h exp 2222", a2m_out); end
        mcu_op(1, 0, 0, 0);
        checks++; if (a2m_ready !== 1'b0 || a2m_out !== 16'h0) begin errors++; $display("FAIL a2m_drained got %b %h exp 0 0000", a2m_ready, a2m_out); end
        n = $urandom_range(DEPTH + 3, 2);
        for (int i = 0; i < n; i++) av_xfer(0, 1, 2'd0, 16'($urandom), 0, 0, 0, 0, got, exp, hs);
        checks++; if (status_out !== model_status()) begin errors++; $display("FAIL a2m_fill_status got %h exp %h", status_out, model_status()); end
        for (int i = 0; i <= DEPTH; i++) begin
            exp = a2m_q.size() > 0 ? a2m_q[0] : 16'h0;
            checks++; if (a2m_out !== exp || a2m_ready !== (a2m_q.size() > 0)) begin errors++; $display("FAIL a2m_pop%0d got %h %b exp %h", i, a2m_out, a2m_ready, exp); end
            mcu_op(1, 0, 0, 0);
        end
        av_xfer(0, 1, 2'd1, 16'h0010, 0, 0, 0, 0, got, exp, hs);
        checks++; if (status_out !== model_status() || status_out[4] !== 1'b0) begin errors++; $display("FAIL a2m_ovf_clr got %h exp %h", status_out, model_status()); end
    endtask

    task automatic test_m2a();
        logic [15:0] got, exp; logic hs;
        logic [15:0] words[DEPTH + 1];
        for (int i = 0; i <= DEPTH; i++) begin words[i] = 16'($urandom); mcu_op(0, 0, words[i], 1); end
        checks++; if (status_out[3] !== 1'b1 || status_out[6] !== 1'b1) begin errors++; $display("FAIL m2a_full_ovf got %h exp bits 3,6 set", status_out); end
        for (int i = 0; i < DEPTH; i++) begin
            av_xfer(1, 0, 2'd0, 0, 0, 0, 0, 0, got, exp, hs);
            checks++; if (got !== words[i] || got !== exp || !hs) begin errors++; $display("FAIL m2a_rd%0d got %h exp %h", i, got, words[i]); end
        end
        av_xfer(1, 0, 2'd0, 0, 0, 0, 0, 0, got, exp, hs);
        checks++; if (got !== 16'h0 || status_out[5] !== 1'b1) begin errors++; $display("FAIL m2a_unf got %h %h exp 0000 unf=1", got, status_out); end
        av_xfer(0, 1, 2'd1, 16'h0070, 0, 0, 0, 0, got, exp, hs);
        checks++; if (status_out[6:4] !== 3'b0 || status_out !== model_status()) begin errors++; $display("FAIL m2a_w1c got %h exp %h", status_out, model_status()); end
    endtask

    task automatic test_doorbell();
        logic [15:0] got, exp; logic hs;
        logic [DB-1:0] s, c;
        av_xfer(0, 1, 2'd3, 16'h0005, 0, 0, 0, 0, got, exp, hs);
        checks++; if (db_pending !== 1'b1 || status_out[11:8] !== 4'h5) begin errors++; $display("FAIL db_set got %b %h exp 1 5", db_pending, status_out[11:8]); end
        av_xfer(0, 1, 2'd3, 16'h0001, 0, 1, 16'h0001, 0, got, exp, hs);
        checks++; if (status_out[11:8] !== 4'h5) begin errors++; $display("FAIL db_set_wins got %h exp 5", status_out[11:8]); end
        mcu_op(0, 1, 16'h0005, 0);
        checks++; if (db_pending !== 1'b0) begin errors++; $display("FAIL db_clear got %b exp 0", db_pending); end
        for (int i = 0; i < 10; i++) begin
            s = DB'($urandom); c = DB'($urandom);
            av_xfer(0, 1, 2'd3, {12'h0, s}, 0, 1'($urandom), {12'h0, c}, 0, got, exp, hs);
            av_xfer(1, 0, 2'd3, 0, 0, 0, 0, 0, got, exp, hs);
            checks++; if (got !== exp || db_pending !== (db != 0) || status_out !== model_status()) begin errors++; $display("FAIL db_rand%0d got %h %h exp %h %h", i, got, status_out, exp, model_status()); end
        end
    endtask

    task automatic test_scratch();
        logic [15:0] got, exp, v; logic hs;
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            av_xfer(0, 1, 2'd2, v, 0, 0, 0, 0, got, exp, hs);
            checks++; if (got !== exp) begin errors++; $display("FAIL scr_hold%0d got %h exp %h", i, got, exp); end
            av_xfer(1, 0, 2'd2, 0, 0, 0, 0, 0, got, exp, hs);
            checks++; if (got !== v) begin errors++; $display("FAIL scr_rd%0d got %h exp %h", i, got, v); end
        end
        v = 16'($urandom) | 16'h1;
        av_xfer(1, 1, 2'd2, v, 0, 0, 0, 0, got, exp, hs);
        checks++; if (got !== 16'h0) begin errors++; $display("FAIL rw_both got %h exp 0000", got); end
        av_xfer(1, 0, 2'd2, 0, 0, 0, 0, 0, got, exp, hs);
        checks++; if (got !== v) begin errors++; $display("FAIL rw_both_wr got %h exp %h", got, v); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, exp; logic hs;
        av_xfer(0, 1, 2'd0, 16'hA001, 0, 0, 0, 0, got, exp, hs);
        av_xfer(0, 1, 2'd0, 16'hA002, 0, 0, 0, 0, got, exp, hs);
        av_xfer(0, 1, 2'd0, 16'hA003, 1, 0, 0, 0, got, exp, hs);
        checks++; if (a2m_out !== 16'hA002 || a2m_q.size() != 2) begin errors++; $display("FAIL pushpop got %h exp A002", a2m_out); end
        while (a2m_q.size() < DEPTH) av_xfer(0, 1, 2'd0, 16'($urandom), 0, 0, 0, 0, got, exp, hs);
        av_xfer(0, 1, 2'd0, 16'hDEAD, 1, 0, 0, 0, got, exp, hs);
        checks++; if (status_out[4] !== 1'b1 || status_out[1] !== 1'b0 || status_out !== model_status()) begin errors++; $display("FAIL full_pushpop got %h exp %h", status_out, model_status()); end
        mcu_op(0, 0, 16'hB001, 1);
        av_xfer(1, 0, 2'd0, 0, 0, 0, 16'hB002, 1, got, exp, hs);
        checks++; if (got !== 16'hB001 || status_out[2] !== 1'b0) begin errors++; $display("FAIL m2a_pushpop got %h %h exp B001", got, status_out); end
        while (m2a_q.size() < DEPTH) mcu_op(0, 0, 16'($urandom), 1);
        av_xfer(0, 1, 2'd1, 16'h0040, 0, 0, 16'hC000, 1, got, exp, hs);
        checks++; if (status_out[6] !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got %h exp bit6 set", status_out); end
        while (a2m_q.size() > 0) mcu_op(1, 0, 0, 0);
        while (m2a_q.size() > 0) av_xfer(1, 0, 2'd0, 0, 0, 0, 0, 0, got, exp, hs);
        av_xfer(0, 1, 2'd1, 16'h0070, 0, 0, 0, 0, got, exp, hs);
        checks++; if (status_out !== model_status()) begin errors++; $display("FAIL b2b_final got %h exp %h", status_out, model_status()); end
    endtask

    task automatic test_held_read();
        logic [15:0] got, exp; logic hs;
        logic [15:0] w[3];
        int acks = 0, pops;
        for (int i = 0; i < 3; i++) begin w[i] = 16'($urandom); mcu_op(0, 0, w[i], 1); end
        @(negedge sysclk);
        s0_read = 1; s0_address = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (s0_waitrequest === 1'b0) begin acks++; got = s0_readdata; end
            @(posedge sysclk); @(negedge sysclk);
        end
        s0_read = 0;
        pops = 3 - 0;
        for (int i = 0; i < 2; i++) begin void'(m2a_q.pop_front()); pops--; end
        last_rd = w[1];
        checks++; if (acks != 2) begin errors++; $display("FAIL held_acks got %0d exp 2", acks); end
        checks++; if (got !== w[1]) begin errors++; $display("FAIL held_data got %h exp %h", got, w[1]); end
        av_xfer(1, 0, 2'd0, 0, 0, 0, 0, 0, got, exp, hs);
        checks++; if (got !== w[2] || pops != 1) begin errors++; $display("FAIL held_remaining got %h exp %h", got, w[2]); end
    endtask

    task automatic test_reset_mid();
        @(negedge sysclk);
        s0_write = 1; s0_address = 2'd0; s0_writedata = 16'hABCD;
        #2 sysreset = 1;
        @(posedge sysclk); @(negedge sysclk);
        checks++; if (s0_waitrequest !== 1'b1 || a2m_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got %b %b exp 1 0", s0_waitrequest, a2m_ready); end
        sysreset = 0; model_reset();
        #1;
        checks++; if (s0_waitrequest !== 1'b1 || s0_readdata !== 16'h0) begin errors++; $display("FAIL mid_fresh got %b %h exp 1 0000", s0_waitrequest, s0_readdata); end
        void'(model_step(0, 1, 2'd0, 16'hABCD, 0, 0, 0, 0));
        @(posedge sysclk); @(negedge sysclk);
        checks++; if (s0_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_ack got %b exp 0", s0_waitrequest); end
        @(posedge sysclk); #1 s0_write = 0;
        checks++; if (a2m_out !== 16'hABCD || a2m_q.size() != 1 || status_out !== model_status()) begin errors++; $display("FAIL mid_push got %h %h exp ABCD %h", a2m_out, status_out, model_status()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_a2m();
        test_m2a();
        test_doorbell();
        test_scratch();
        test_back_to_back();
        test_held_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
